// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
//   rst_state_e : sequencer FSM states (ASSERT -> RELEASE -> RUN)
//   CAUSE_*     : reset-cause codes reported on rst_sequencer.cause
//   KEY_RELEASED: level of the active-low push-button when not pressed
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR = 2'd0;
  localparam logic [1:0] CAUSE_PLL = 2'd1;
  localparam logic [1:0] CAUSE_KEY = 2'd2;
  localparam logic [1:0] CAUSE_SW  = 2'd3;

  localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/rst_debounce.sv
// Push-button synchroniser and debounce filter.
//   clk, reset : system clock, synchronous active-high reset
//   key_n      : asynchronous, bouncy, active-low button pin
//   key_db     : debounced level (1 = released), registered
//   press      : one-cycle registered pulse when key_db goes released -> pressed
// The debounced level only changes after the synchronised pin has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; one agreeing sample restarts
// the count.
module rst_debounce
  import rst_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic key_db,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   press_q, press_d;
  logic                   key_s;

  assign key_s  = sync_q[SYNC_STAGES-1];
  assign key_db = db_q;
  assign press  = press_q;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], key_n};
    db_d    = db_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (key_s == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // This sample is the DEBOUNCE_CYCLES-th consecutive disagreement.
      db_d    = key_s;
      cnt_d   = '0;
      press_d = (key_s != KEY_RELEASED);
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{KEY_RELEASED}};
      db_q    <= KEY_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

endmodule

// File: rtl/rst_sequencer.sv
// Power-on / reset sequencer for the board tops.
//   clk        : system clock
//   reset      : synchronous active-high; full resequence with cause=POR
//   pll_locked : asynchronous PLL lock (low = unlocked), synchronised only
//   key_n      : asynchronous active-low push-button, synchronised + debounced
//   sw_req     : one-cycle software reset request in the clk domain; it is a
//                pulse, not a handshake, and is only honoured in RELEASE/RUN
//   rst_out    : NUM_RST active-high domain resets, released in ascending order
//   busy       : high while any rst_out bit is high
//   cause      : cause of the last reset (CAUSE_POR/PLL/KEY/SW)
//   dbg_state  : current sequencer FSM state
// All outputs come straight from flops so they cannot glitch.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_RST         = 3,
  parameter int HOLD_CYCLES     = 32,
  parameter int GAP_CYCLES      = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_locked,
  input  logic               key_n,
  input  logic               sw_req,
  output logic [NUM_RST-1:0] rst_out,
  output logic               busy,
  output logic [1:0]         cause,
  output rst_state_e         dbg_state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int IDX_W  = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;

  rst_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]       gap_inc;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       next_idx;
  logic [NUM_RST-1:0]     rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic [1:0]             cause_q, cause_d;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;

  logic locked_s;
  logic key_db;
  logic key_press;
  logic qualified;
  logic trigger;

  rst_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_key_db (
    .clk   (clk),
    .reset (reset),
    .key_n (key_n),
    .key_db(key_db),
    .press (key_press)
  );

  // Lock loss must act immediately, so the PLL lock only gets a synchroniser.
  assign lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s    = lock_sync_q[SYNC_STAGES-1];

  assign qualified = locked_s && (key_db == KEY_RELEASED);
  assign trigger   = (state_q != ST_ASSERT) && (!locked_s || key_press || sw_req);
  assign next_idx  = idx_q + IDX_W'(1);
  assign gap_inc   = gap_cnt_q + GAP_W'(1);

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    rst_out_d  = rst_out_q;
    busy_d     = busy_q;
    cause_d    = cause_q;

    unique case (state_q)
      ST_ASSERT: begin
        rst_out_d = '1;
        busy_d    = 1'b1;
        gap_cnt_d = '0;
        idx_d     = '0;
        // Lock loss or a held key restarts the hold window; cause is kept.
        if (!qualified) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(HOLD_CYCLES)) begin
          hold_cnt_d = '0;
          if (NUM_RST == 1) begin
            state_d   = ST_RUN;
            rst_out_d = '0;
            busy_d    = 1'b0;
          end else begin
            state_d   = ST_RELEASE;
            rst_out_d = ~NUM_RST'(1);
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end

      ST_RELEASE: begin
        // idx_q is the most recently released domain.
        if (gap_inc == GAP_W'(GAP_CYCLES)) begin
          gap_cnt_d = '0;
          idx_d     = next_idx;
          rst_out_d = rst_out_q & ~(NUM_RST'(1) << next_idx);
          if (next_idx == IDX_W'(NUM_RST - 1)) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
          end
        end else begin
          gap_cnt_d = gap_inc;
        end
      end

      ST_RUN: begin
        rst_out_d = '0;
        busy_d    = 1'b0;
      end

      default: begin
        state_d   = ST_ASSERT;
        rst_out_d = '1;
        busy_d    = 1'b1;
      end
    endcase

    // Re-assertion overrides any sequencing step and drops all bits together.
    if (trigger) begin
      state_d    = ST_ASSERT;
      rst_out_d  = '1;
      busy_d     = 1'b1;
      hold_cnt_d = '0;
      gap_cnt_d  = '0;
      idx_d      = '0;
      if (!locked_s)      cause_d = CAUSE_PLL;
      else if (key_press) cause_d = CAUSE_KEY;
      else                cause_d = CAUSE_SW;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      busy_q      <= 1'b1;
      cause_q     <= CAUSE_POR;
      lock_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      busy_q      <= busy_d;
      cause_q     <= cause_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign busy      = busy_q;
  assign cause     = cause_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench for rst_sequencer with NUM_RST=3 HOLD=8 GAP=4 DEBOUNCE=4 SYNC=2.
// Edge numbers are counted from the first rising edge with reset low; inputs
// driven 1 ns after edge k are sampled on edge k+1, outputs are checked 1 ns
// after each edge.
module tb_rst_sequencer;
  import rst_seq_pkg::*;

  logic       clk        = 1'b0;
  logic       reset      = 1'b1;
  logic       pll_locked = 1'b1;
  logic       key_n      = 1'b1;
  logic       sw_req     = 1'b0;
  logic [2:0] rst_out;
  logic       busy;
  logic [1:0] cause;
  rst_state_e dbg_state;

  int ecount = 0;
  int n_vec  = 0;
  int n_miss = 0;

  rst_sequencer #(
    .NUM_RST        (3),
    .HOLD_CYCLES    (8),
    .GAP_CYCLES     (4),
    .DEBOUNCE_CYCLES(4),
    .SYNC_STAGES    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pll_locked(pll_locked),
    .key_n     (key_n),
    .sw_req    (sw_req),
    .rst_out   (rst_out),
    .busy      (busy),
    .cause     (cause),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @edge%0d: got %0h expected %0h", tag, ecount, got, exp);
    end
  endtask

  task automatic expect_out(input logic [2:0] r, input logic b, input logic [1:0] c,
                            input rst_state_e s);
    check_val("rst_out", 32'(rst_out), 32'(r));
    check_val("busy", 32'(busy), 32'(b));
    check_val("cause", 32'(cause), 32'(c));
    check_val("state", 32'(dbg_state), 32'(s));
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  task automatic run_to(input int e);
    while (ecount < e) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    expect_out(3'b111, 1'b1, CAUSE_POR, ST_ASSERT);
    reset  = 1'b0;
    ecount = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] bounce;
    bounce = 4'b0101;  // key_n per edge 58..61 (bit0 first): 1,0,1,0

    // Stable lock from reset.
    pll_locked = 1'b1;
    apply_reset();
    run_to(10); expect_out(3'b111, 1'b1, CAUSE_POR, ST_ASSERT);
    run_to(11); expect_out(3'b110, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(14); expect_out(3'b110, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(15); expect_out(3'b100, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(18); expect_out(3'b100, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(19); expect_out(3'b000, 1'b0, CAUSE_POR, ST_RUN);

    // Lock arrives late: sampled on edge 21, release of bit 0 on edge 31.
    pll_locked = 1'b0;
    apply_reset();
    for (int e = 1; e <= 20; e++) begin
      run_to(e);
      check_val("no_lock_hold", 32'(rst_out), 32'h7);
    end
    pll_locked = 1'b1;
    for (int e = 21; e <= 30; e++) begin
      run_to(e);
      check_val("late_lock_hold", 32'(rst_out), 32'h7);
    end
    run_to(31); expect_out(3'b110, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(35); expect_out(3'b100, 1'b1, CAUSE_POR, ST_RELEASE);
    run_to(39); expect_out(3'b000, 1'b0, CAUSE_POR, ST_RUN);

    // Software request in RUN.
    sw_req = 1'b1;
    step();                       // edge 40
    sw_req = 1'b0;
    expect_out(3'b111, 1'b1, CAUSE_SW, ST_ASSERT);
    run_to(48); expect_out(3'b111, 1'b1, CAUSE_SW, ST_ASSERT);
    run_to(49); expect_out(3'b110, 1'b1, CAUSE_SW, ST_RELEASE);
    run_to(53); expect_out(3'b100, 1'b1, CAUSE_SW, ST_RELEASE);
    run_to(57); expect_out(3'b000, 1'b0, CAUSE_SW, ST_RUN);

    // Bouncing key, then held low from edge 61: trigger on edge 67.
    for (int i = 0; i < 4; i++) begin
      key_n = bounce[i];
      step();                     // edges 58..61
      check_val("bounce_run", 32'(rst_out), 32'h0);
    end
    for (int e = 62; e <= 66; e++) begin
      run_to(e);
      check_val("debounce_wait", 32'(rst_out), 32'h0);
    end
    run_to(67); expect_out(3'b111, 1'b1, CAUSE_KEY, ST_ASSERT);
    for (int e = 68; e <= 75; e++) begin
      run_to(e);
      check_val("key_held", 32'(rst_out), 32'h7);
    end
    key_n = 1'b1;                 // sampled 76, debounced released on 81
    run_to(89); expect_out(3'b111, 1'b1, CAUSE_KEY, ST_ASSERT);
    run_to(90); expect_out(3'b110, 1'b1, CAUSE_KEY, ST_RELEASE);
    run_to(94); expect_out(3'b100, 1'b1, CAUSE_KEY, ST_RELEASE);

    // Lock loss in RELEASE: sampled on 95, re-asserted on 97.
    pll_locked = 1'b0;
    run_to(95); check_val("pll_drop_95", 32'(rst_out), 32'h4);
    run_to(96); check_val("pll_drop_96", 32'(rst_out), 32'h4);
    run_to(97); expect_out(3'b111, 1'b1, CAUSE_PLL, ST_ASSERT);
    pll_locked = 1'b1;
    run_to(107); expect_out(3'b111, 1'b1, CAUSE_PLL, ST_ASSERT);
    run_to(108); expect_out(3'b110, 1'b1, CAUSE_PLL, ST_RELEASE);
    run_to(112); expect_out(3'b100, 1'b1, CAUSE_PLL, ST_RELEASE);
    run_to(116); expect_out(3'b000, 1'b0, CAUSE_PLL, ST_RUN);

    // sw_req on the same edge that sees locked_s low: PLL wins.
    pll_locked = 1'b0;
    run_to(117); check_val("pre_tie_117", 32'(rst_out), 32'h0);
    run_to(118); check_val("pre_tie_118", 32'(rst_out), 32'h0);
    sw_req = 1'b1;
    step();                       // edge 119
    sw_req = 1'b0;
    expect_out(3'b111, 1'b1, CAUSE_PLL, ST_ASSERT);
    pll_locked = 1'b1;            // locked_s high after 121, release on 130
    run_to(123);
    sw_req = 1'b1;                // ignored while in ASSERT
    step();                       // edge 124
    sw_req = 1'b0;
    expect_out(3'b111, 1'b1, CAUSE_PLL, ST_ASSERT);
    run_to(129); expect_out(3'b111, 1'b1, CAUSE_PLL, ST_ASSERT);
    run_to(130); expect_out(3'b110, 1'b1, CAUSE_PLL, ST_RELEASE);
    run_to(134); expect_out(3'b100, 1'b1, CAUSE_PLL, ST_RELEASE);

    // Reset mid-RELEASE.
    reset = 1'b1;
    step();                       // edge 135
    expect_out(3'b111, 1'b1, CAUSE_POR, ST_ASSERT);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
